// File: rtl/dav_collect_pkg.sv
// Shared definitions for the DAV collection block: parameter defaults,
// counter widths and the collection FSM state encoding.
package dav_collect_pkg;

    localparam int NSRC_DEF   = 7;
    localparam int TMO_DEF    = 400;
    localparam int PDEPTH_DEF = 4;

    localparam int TMR_W = 9;
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/dav_edge.sv
// Registers the synchronized DAV levels and flags the bits that rose this cycle.
module dav_edge #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] dav_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] dav_q;

    // previous-cycle DAV levels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dav_q <= {W{1'b0}};
        end else begin
            dav_q <= dav_i;
        end
    end

    assign rise_o = dav_i & ~dav_q;

endmodule

// File: rtl/dav_collect.sv
// Collects per-source DAV edges inside a window opened by each L1A match and
// presents the reporting mask, the missing mask and a timeout flag until acknowledged.
module dav_collect
    import dav_collect_pkg::*;
#(
    parameter int NSRC   = NSRC_DEF,
    parameter int TMO    = TMO_DEF,
    parameter int PDEPTH = PDEPTH_DEF
) (
    input  logic              C,
    input  logic              RST,
    input  logic [NSRC-1:0]   DAV,
    input  logic              L1A_MATCH,
    input  logic [NSRC-1:0]   EXPECT,
    input  logic              RD_ACK,
    output logic              MASK_VLD,
    output logic [NSRC-1:0]   MASK,
    output logic [NSRC-1:0]   MISS,
    output logic              TMO_FLG,
    output logic [CNT_W-1:0]  EVT_CNT,
    output logic              OVF
);

    localparam int               PW        = $clog2(PDEPTH + 1);
    localparam logic [PW-1:0]    PEND_MAX  = PW'(PDEPTH);
    localparam logic [PW-1:0]    PEND_ONE  = PW'(1);
    localparam logic [PW-1:0]    PEND_ZERO = PW'(0);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TMO - 1);

    state_e             state_q;
    logic [PW-1:0]      pend_q;
    logic [PW-1:0]      pend_d;
    logic [NSRC-1:0]    exp_q;
    logic [NSRC-1:0]    got_q;
    logic [NSRC-1:0]    got_d;
    logic [TMR_W-1:0]   timer_q;
    logic [NSRC-1:0]    rise_s;
    logic               cover_s;
    logic               last_s;
    logic               start_s;
    logic               accept_s;
    logic               drop_s;

    dav_edge #(
        .W (NSRC)
    ) u_dav_edge (
        .clk_i  (C),
        .rst_i  (RST),
        .dav_i  (DAV),
        .rise_o (rise_s)
    );

    // Window coverage and pending-request bookkeeping; an edge in the closing
    // cycle still counts toward coverage, and a full queue may still accept a
    // request in the cycle a window starts because that start frees a slot.
    always_comb begin
        got_d    = got_q | rise_s;
        cover_s  = ((got_d & exp_q) == exp_q);
        last_s   = (timer_q == TMO_LAST);
        start_s  = (state_q == ST_IDLE) && ((pend_q != PEND_ZERO) || L1A_MATCH);
        accept_s = L1A_MATCH && ((pend_q != PEND_MAX) || start_s);
        drop_s   = L1A_MATCH && !accept_s;
        if (accept_s && !start_s) begin
            pend_d = pend_q + PEND_ONE;
        end else if (start_s && !accept_s) begin
            pend_d = pend_q - PEND_ONE;
        end else begin
            pend_d = pend_q;
        end
    end

    // Collection FSM with registered result outputs
    always_ff @(posedge C) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pend_q   <= PEND_ZERO;
            exp_q    <= {NSRC{1'b0}};
            got_q    <= {NSRC{1'b0}};
            timer_q  <= {TMR_W{1'b0}};
            MASK_VLD <= 1'b0;
            MASK     <= {NSRC{1'b0}};
            MISS     <= {NSRC{1'b0}};
            TMO_FLG  <= 1'b0;
            EVT_CNT  <= {CNT_W{1'b0}};
            OVF      <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (drop_s) begin
                OVF <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q <= ST_COLLECT;
                        exp_q   <= EXPECT;
                        got_q   <= {NSRC{1'b0}};
                        timer_q <= {TMR_W{1'b0}};
                    end
                end
                ST_COLLECT: begin
                    got_q   <= got_d;
                    timer_q <= timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
                    if (cover_s || last_s) begin
                        state_q  <= ST_PRESENT;
                        MASK_VLD <= 1'b1;
                        MASK     <= got_d;
                        MISS     <= exp_q & ~got_d;
                        TMO_FLG  <= !cover_s;
                    end
                end
                ST_PRESENT: begin
                    if (RD_ACK) begin
                        state_q  <= ST_IDLE;
                        MASK_VLD <= 1'b0;
                        EVT_CNT  <= EVT_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    MASK_VLD <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dav_collect.sv
// Directed bench for dav_collect with a cycle-level reference model checked on every cycle.
module tb_dav_collect;

    localparam int NSRC   = 7;
    localparam int TMO    = 400;
    localparam int PDEPTH = 4;

    logic            C = 1'b0;
    logic            RST = 1'b1;
    logic [NSRC-1:0] DAV = 7'h00;
    logic            L1A_MATCH = 1'b0;
    logic [NSRC-1:0] EXPECT = 7'h00;
    logic            RD_ACK = 1'b0;
    logic            MASK_VLD;
    logic [NSRC-1:0] MASK;
    logic [NSRC-1:0] MISS;
    logic            TMO_FLG;
    logic [11:0]     EVT_CNT;
    logic            OVF;

    dav_collect #(
        .NSRC   (NSRC),
        .TMO    (TMO),
        .PDEPTH (PDEPTH)
    ) dut (
        .C         (C),
        .RST       (RST),
        .DAV       (DAV),
        .L1A_MATCH (L1A_MATCH),
        .EXPECT    (EXPECT),
        .RD_ACK    (RD_ACK),
        .MASK_VLD  (MASK_VLD),
        .MASK      (MASK),
        .MISS      (MISS),
        .TMO_FLG   (TMO_FLG),
        .EVT_CNT   (EVT_CNT),
        .OVF       (OVF)
    );

    always #5 C = ~C;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 window open, 2 result shown
    int              m_phase = 0;
    int              m_pend  = 0;
    int              m_age   = 0;
    int              m_cnt   = 0;
    logic [NSRC-1:0] m_prev  = 7'h00;
    logic [NSRC-1:0] m_exp   = 7'h00;
    logic [NSRC-1:0] m_got   = 7'h00;
    logic            m_vld   = 1'b0;
    logic [NSRC-1:0] m_mask  = 7'h00;
    logic [NSRC-1:0] m_miss  = 7'h00;
    logic            m_tmo   = 1'b0;
    logic            m_ovf   = 1'b0;

    task automatic model_step();
        logic [NSRC-1:0] rise;
        bit starting;
        if (RST) begin
            m_phase = 0; m_pend = 0; m_age = 0; m_cnt = 0;
            m_prev = 7'h00; m_exp = 7'h00; m_got = 7'h00;
            m_vld = 1'b0; m_mask = 7'h00; m_miss = 7'h00; m_tmo = 1'b0; m_ovf = 1'b0;
        end else begin
            rise = DAV & ~m_prev;
            m_prev = DAV;
            starting = (m_phase == 0) && (m_pend > 0 || L1A_MATCH);
            if (L1A_MATCH) begin
                if (m_pend < PDEPTH || starting) m_pend++;
                else m_ovf = 1'b1;
            end
            if (starting) m_pend--;
            if (m_phase == 0) begin
                if (starting) begin
                    m_phase = 1; m_exp = EXPECT; m_got = 7'h00; m_age = 0;
                end
            end else if (m_phase == 1) begin
                m_got = m_got | rise;
                m_age++;
                if ((m_got & m_exp) == m_exp || m_age == TMO) begin
                    m_phase = 2;
                    m_vld  = 1'b1;
                    m_mask = m_got;
                    m_miss = m_exp & ~m_got;
                    m_tmo  = ((m_got & m_exp) != m_exp);
                end
            end else begin
                if (RD_ACK) begin
                    m_phase = 0; m_vld = 1'b0; m_cnt = (m_cnt + 1) % 4096;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge C);
            model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge C);
            if (chk_en) begin
                chk("mdl_vld", MASK_VLD, m_vld);
                chk("mdl_cnt", EVT_CNT, m_cnt);
                chk("mdl_ovf", OVF, m_ovf);
                if (m_vld) begin
                    chk("mdl_mask", MASK, m_mask);
                    chk("mdl_miss", MISS, m_miss);
                    chk("mdl_tmo", TMO_FLG, m_tmo);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic wait_vld(input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge C);
            if (MASK_VLD) return;
        end
        chk("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_evt(input logic [NSRC-1:0] e);
        EXPECT = e; L1A_MATCH = 1'b1;
        tick();
        L1A_MATCH = 1'b0;
        wait_vld(TMO + 10);
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
    endtask

    // L1A in cycle 0; DAV bits rise at cycles ca/cb; result expected at cycle vc
    task automatic run_win(input logic [NSRC-1:0] e, input int ca, input int ba,
                           input int cb, input int bb, input int vc,
                           input logic [NSRC-1:0] mk, input logic [NSRC-1:0] ms,
                           input logic tf, input logic [11:0] cnt);
        EXPECT = e; L1A_MATCH = 1'b1;
        tick();
        L1A_MATCH = 1'b0;
        for (int k = 1; k <= vc; k++) begin
            if (k == ca) DAV[ba] = 1'b1;
            if (k == cb) DAV[bb] = 1'b1;
            @(negedge C);
            if (k == vc - 1) chk("win_vld_early", MASK_VLD, 1'b0);
            if (k == vc) begin
                chk("win_vld", MASK_VLD, 1'b1);
                chk("win_mask", MASK, mk);
                chk("win_miss", MISS, ms);
                chk("win_tmo", TMO_FLG, tf);
            end
            if (k < vc) tick();
        end
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        DAV = 7'h00;
        @(negedge C);
        chk("win_cnt", EVT_CNT, cnt);
        chk("win_vld_drop", MASK_VLD, 1'b0);
        tick();
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        @(negedge C);
        chk("rst_vld", MASK_VLD, 1'b0);
        chk("rst_cnt", EVT_CNT, 12'd0);
        chk("rst_ovf", OVF, 1'b0);
        chk("rst_mask", MASK, 7'h00);
        // acknowledge while idle does nothing
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        @(negedge C);
        chk("idle_ack_cnt", EVT_CNT, 12'd0);
        tick();

        run_win(7'h05, 3, 0, 10, 2, 11, 7'h05, 7'h00, 1'b0, 12'd1);
        run_win(7'h00, 1, 3, -1, 0, 2, 7'h08, 7'h00, 1'b0, 12'd2);
        run_win(7'h03, 5, 0, -1, 0, TMO + 1, 7'h01, 7'h02, 1'b1, 12'd3);
        run_win(7'h03, 2, 0, TMO, 1, TMO + 1, 7'h03, 7'h00, 1'b0, 12'd4);

        // reset while a result is presented
        EXPECT = 7'h00; L1A_MATCH = 1'b1;
        tick();
        L1A_MATCH = 1'b0;
        wait_vld(10);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge C);
        chk("rstp_vld", MASK_VLD, 1'b0);
        chk("rstp_cnt", EVT_CNT, 12'd0);
        tick();
        run_win(7'h01, 1, 0, -1, 0, 2, 7'h01, 7'h00, 1'b0, 12'd1);

        // overflow: five requests while the first window is collecting
        do_reset();
        EXPECT = 7'h01; L1A_MATCH = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        L1A_MATCH = 1'b0;
        EXPECT = 7'h00;
        @(negedge C);
        chk("ovf_set", OVF, 1'b1);
        wait_vld(TMO + 10);
        chk("ovf_w1_tmo", TMO_FLG, 1'b1);
        chk("ovf_w1_miss", MISS, 7'h01);
        RD_ACK = 1'b1; tick(); RD_ACK = 1'b0;
        for (int w = 0; w < 4; w++) begin
            wait_vld(10);
            RD_ACK = 1'b1; tick(); RD_ACK = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge C);
            chk("ovf_no_extra", MASK_VLD, 1'b0);
            tick();
        end
        chk("ovf_cnt", EVT_CNT, 12'd5);
        chk("ovf_sticky", OVF, 1'b1);

        // event counter wrap
        do_reset();
        for (int i = 0; i < 4095; i++) do_evt(7'h00);
        @(negedge C);
        chk("wrap_4095", EVT_CNT, 12'd4095);
        tick();
        do_evt(7'h00);
        @(negedge C);
        chk("wrap_0", EVT_CNT, 12'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
